// File: rtl/aud_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// aud_frame_fifo_if
// Bundle of the sample-write, frame-read and status signals of the audio
// frame FIFO.
//   master : drives wr_en/wr_sof/wr_data, rd_en and clr_flags;
//            observes rd_data/rd_valid, full/empty/count and sticky flags.
//   slave  : the FIFO itself (mirror image of master).
// Parameters must match those of the aud_frame_fifo instance it is bound to.
// ---------------------------------------------------------------------------
interface aud_frame_fifo_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16
);
    logic                         wr_en;
    logic                         wr_sof;
    logic [DATA_W-1:0]            wr_data;
    logic                         rd_en;
    logic [NUM_CH*DATA_W-1:0]     rd_data;
    logic                         rd_valid;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         underflow;
    logic                         sync_err;
    logic                         clr_flags;

    modport master (
        output wr_en, wr_sof, wr_data, rd_en, clr_flags,
        input  rd_data, rd_valid, full, empty, count,
               overflow, underflow, sync_err
    );

    modport slave (
        input  wr_en, wr_sof, wr_data, rd_en, clr_flags,
        output rd_data, rd_valid, full, empty, count,
               overflow, underflow, sync_err
    );
endinterface

// File: rtl/aud_frame_fifo.sv
// ---------------------------------------------------------------------------
// aud_frame_fifo
// Collects NUM_CH consecutive samples into a staging frame and commits each
// complete frame into a DEPTH-entry FIFO; rd_en pops one whole frame with a
// one-cycle latency.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : aud_frame_fifo_if.slave
//           wr_en/wr_sof/wr_data  sample input, channels in order 0..NUM_CH-1
//           rd_en                 pop request
//           rd_data/rd_valid      popped frame (channel 0 in LSBs), mute on
//                                 underflow, held when idle
//           full/empty/count      registered occupancy
//           overflow/underflow/sync_err  sticky, cleared by clr_flags
// OVERWRITE=0 drops the newest frame when full, OVERWRITE=1 drops the oldest.
// ---------------------------------------------------------------------------
module aud_frame_fifo #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    aud_frame_fifo_if.slave bus
);
    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [FRAME_W-1:0] mem [DEPTH];

    logic [CH_W-1:0]    ch_q, ch_d;
    logic [FRAME_W-1:0] stage_q, stage_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [FRAME_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               sync_err_q, sync_err_d;

    logic               resync;
    logic               commit;
    logic               pop_ok;
    logic               push_ok;
    logic               drop_old;
    logic               ovf_evt;
    logic               udf_evt;
    logic [NUM_CH-1:0]  slot_we;

    // A start-of-frame in the middle of a frame restarts the staging frame.
    assign resync = bus.wr_en && bus.wr_sof && (ch_q != '0);

    // Per-channel staging slots. stage_d already contains the sample being
    // written this cycle, so it is the frame to commit on the last channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            if (gi == 0) begin : g_ch0
                assign slot_we[gi] = bus.wr_en && ((ch_q == '0) || bus.wr_sof);
            end else begin : g_chn
                assign slot_we[gi] = bus.wr_en && !resync && (ch_q == CH_W'(gi));
            end
            assign stage_d[gi*DATA_W +: DATA_W] =
                slot_we[gi] ? bus.wr_data : stage_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        commit   = bus.wr_en && !resync && (ch_q == LAST_CH);
        pop_ok   = bus.rd_en && !empty_q;
        udf_evt  = bus.rd_en && empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO only
        // overflows when no successful pop accompanies the commit.
        ovf_evt  = commit && full_q && !pop_ok;
        drop_old = ovf_evt && OVERWRITE;
        push_ok  = commit && !(ovf_evt && !OVERWRITE);

        ch_d = ch_q;
        if (resync) begin
            ch_d = CH_W'(1);
        end else if (bus.wr_en) begin
            ch_d = commit ? '0 : ch_q + CH_W'(1);
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok || drop_old);

        count_d = count_q;
        if (push_ok && !pop_ok && !drop_old) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);

        rd_valid_d = pop_ok;
        rd_data_d  = rd_data_q;
        if (pop_ok) begin
            rd_data_d = mem[rd_ptr_q];
        end else if (udf_evt) begin
            rd_data_d = '0;
        end

        // New events take priority over clr_flags.
        overflow_d  = (overflow_q  && !bus.clr_flags) || ovf_evt;
        underflow_d = (underflow_q && !bus.clr_flags) || udf_evt;
        sync_err_d  = (sync_err_q  && !bus.clr_flags) || resync;
    end

    // Frame storage: no reset, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= stage_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q        <= '0;
            stage_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            stage_q     <= stage_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_aud_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_aud_frame_fifo
// Drives identical stimulus into two FIFOs (drop-newest and drop-oldest),
// compares both against a queue-based model every cycle, and pins the model
// with hand-computed directed expectations.
// ---------------------------------------------------------------------------
module tb_aud_frame_fifo;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int FW     = NUM_CH * DATA_W;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              wr_en     = 1'b0;
    logic              wr_sof    = 1'b0;
    logic [DATA_W-1:0] wr_data   = '0;
    logic              rd_en     = 1'b0;
    logic              clr_flags = 1'b0;

    int checks   = 0;
    int failures = 0;

    aud_frame_fifo_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus0 ();
    aud_frame_fifo_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus1 ();

    assign bus0.wr_en = wr_en;     assign bus1.wr_en = wr_en;
    assign bus0.wr_sof = wr_sof;   assign bus1.wr_sof = wr_sof;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
    assign bus0.rd_en = rd_en;     assign bus1.rd_en = rd_en;
    assign bus0.clr_flags = clr_flags;
    assign bus1.clr_flags = clr_flags;

    aud_frame_fifo #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .OVERWRITE(1'b0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    aud_frame_fifo #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .OVERWRITE(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: queues of whole frames, one per policy.
    // ------------------------------------------------------------------
    logic [FW-1:0]     q0[$];
    logic [FW-1:0]     q1[$];
    logic [DATA_W-1:0] m_stage [NUM_CH];
    int                m_ch;
    logic              m_sync;
    logic [FW-1:0]     m_rd_data [2];
    logic              m_valid [2];
    logic              m_ovf [2];
    logic              m_udf [2];

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ch   = 0;
        m_sync = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_stage[k] = '0;
        for (int i = 0; i < 2; i++) begin
            m_rd_data[i] = '0;
            m_valid[i]   = 1'b0;
            m_ovf[i]     = 1'b0;
            m_udf[i]     = 1'b0;
        end
    endtask

    task automatic model_step();
        logic          commit;
        logic          sync_evt;
        logic [FW-1:0] frame;
        logic [FW-1:0] junk;
        commit   = 1'b0;
        sync_evt = 1'b0;
        if (wr_en) begin
            if (wr_sof && m_ch != 0) begin
                m_stage[0] = wr_data;
                m_ch       = 1;
                sync_evt   = 1'b1;
            end else begin
                m_stage[m_ch] = wr_data;
                if (m_ch == NUM_CH - 1) begin
                    commit = 1'b1;
                    m_ch   = 0;
                end else begin
                    m_ch = m_ch + 1;
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) frame[k*DATA_W +: DATA_W] = m_stage[k];
        m_sync = (m_sync && !clr_flags) || sync_evt;

        for (int i = 0; i < 2; i++) begin
            int   sz;
            logic popped;
            logic ovf_evt;
            logic udf_evt;
            sz      = (i == 0) ? q0.size() : q1.size();
            popped  = 1'b0;
            ovf_evt = 1'b0;
            udf_evt = 1'b0;
            m_valid[i] = 1'b0;
            if (rd_en) begin
                if (sz == 0) begin
                    m_rd_data[i] = '0;
                    udf_evt      = 1'b1;
                end else begin
                    m_rd_data[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                    m_valid[i]   = 1'b1;
                    popped       = 1'b1;
                end
            end
            if (commit) begin
                if (sz == DEPTH && !popped) begin
                    ovf_evt = 1'b1;
                    if (i == 1) begin
                        junk = q1.pop_front();
                        q1.push_back(frame);
                    end
                end else if (i == 0) begin
                    q0.push_back(frame);
                end else begin
                    q1.push_back(frame);
                end
            end
            m_ovf[i] = (m_ovf[i] && !clr_flags) || ovf_evt;
            m_udf[i] = (m_udf[i] && !clr_flags) || udf_evt;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [FW-1:0] rd, input logic v,
                            input logic f, input logic e, input logic [CW-1:0] c,
                            input logic ov, input logic ud, input logic se);
        int sz;
        sz = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("inst%0d rd_data", i), 64'(rd), 64'(m_rd_data[i]));
        chk($sformatf("inst%0d rd_valid", i), 64'(v), 64'(m_valid[i]));
        chk($sformatf("inst%0d full", i), 64'(f), 64'(sz == DEPTH));
        chk($sformatf("inst%0d empty", i), 64'(e), 64'(sz == 0));
        chk($sformatf("inst%0d count", i), 64'(c), 64'(sz));
        chk($sformatf("inst%0d overflow", i), 64'(ov), 64'(m_ovf[i]));
        chk($sformatf("inst%0d underflow", i), 64'(ud), 64'(m_udf[i]));
        chk($sformatf("inst%0d sync_err", i), 64'(se), 64'(m_sync));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                cmp_inst(0, bus0.rd_data, bus0.rd_valid, bus0.full, bus0.empty,
                         bus0.count, bus0.overflow, bus0.underflow, bus0.sync_err);
                cmp_inst(1, bus1.rd_data, bus1.rd_valid, bus1.full, bus1.empty,
                         bus1.count, bus1.overflow, bus1.underflow, bus1.sync_err);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic we, input logic sof, input logic [DATA_W-1:0] d,
                       input logic re, input logic clr);
        wr_en = we; wr_sof = sof; wr_data = d; rd_en = re; clr_flags = clr;
        @(negedge clk);
        $display("txn we=%0b sof=%0b d=%h re=%0b clr=%0b -> cnt0=%0d cnt1=%0d rd0=%h v0=%0b rd1=%h v1=%0b",
                 we, sof, d, re, clr, bus0.count, bus1.count, bus0.rd_data,
                 bus0.rd_valid, bus1.rd_data, bus1.rd_valid);
        wr_en = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic write_frame(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
        cyc(1'b1, 1'b0, lo, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, hi, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " empty0"}, 64'(bus0.empty), 64'd1);
        chk({tag, " full0"}, 64'(bus0.full), 64'd0);
        chk({tag, " count0"}, 64'(bus0.count), 64'd0);
        chk({tag, " rd_data0"}, 64'(bus0.rd_data), 64'd0);
        chk({tag, " rd_valid0"}, 64'(bus0.rd_valid), 64'd0);
        chk({tag, " flags0"}, 64'({bus0.overflow, bus0.underflow, bus0.sync_err}), 64'd0);
        chk({tag, " empty1"}, 64'(bus1.empty), 64'd1);
        chk({tag, " count1"}, 64'(bus1.count), 64'd0);
        chk({tag, " flags1"}, 64'({bus1.overflow, bus1.underflow, bus1.sync_err}), 64'd0);
    endtask

    initial begin
        logic [FW-1:0] exp0;
        logic [FW-1:0] exp1;

        repeat (2) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;
        @(negedge clk);

        // Basic frame: 0x0001, 0x0002 -> 0x00020001, latency 1.
        write_frame(16'h0001, 16'h0002);
        chk("basic count", 64'(bus0.count), 64'd1);
        pop();
        chk("basic rd_data", 64'(bus0.rd_data), 64'h0002_0001);
        chk("basic rd_valid", 64'(bus0.rd_valid), 64'd1);
        chk("basic count after pop", 64'(bus0.count), 64'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("basic rd_valid one cycle", 64'(bus0.rd_valid), 64'd0);
        chk("basic rd_data hold", 64'(bus0.rd_data), 64'h0002_0001);

        // Underflow mutes output; clr_flags clears it.
        pop();
        chk("udf rd_data", 64'(bus0.rd_data), 64'd0);
        chk("udf rd_valid", 64'(bus0.rd_valid), 64'd0);
        chk("udf flag", 64'(bus0.underflow), 64'd1);
        clr();
        chk("udf cleared", 64'(bus0.underflow), 64'd0);

        // 17 frames into a 16-deep FIFO under both policies.
        for (int k = 1; k <= 17; k++) begin
            write_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k));
            if (k == 16) begin
                chk("fill full0", 64'(bus0.full), 64'd1);
                chk("fill count0", 64'(bus0.count), 64'd16);
                chk("fill no ovf0", 64'(bus0.overflow), 64'd0);
            end
        end
        chk("ovf flag0", 64'(bus0.overflow), 64'd1);
        chk("ovf flag1", 64'(bus1.overflow), 64'd1);
        chk("ovf count1", 64'(bus1.count), 64'd16);
        chk("ovf full1", 64'(bus1.full), 64'd1);
        for (int k = 1; k <= 16; k++) begin
            pop();
            exp0 = {16'h2000 + 16'(k), 16'h1000 + 16'(k)};
            exp1 = {16'h2000 + 16'(k + 1), 16'h1000 + 16'(k + 1)};
            chk($sformatf("drop-newest pop %0d", k), 64'(bus0.rd_data), 64'(exp0));
            chk($sformatf("drop-oldest pop %0d", k), 64'(bus1.rd_data), 64'(exp1));
        end
        chk("drained empty0", 64'(bus0.empty), 64'd1);
        clr();

        // Resync on mid-frame start-of-frame.
        cyc(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        chk("resync sync_err", 64'(bus0.sync_err), 64'd1);
        chk("resync no commit", 64'(bus0.count), 64'd0);
        cyc(1'b1, 1'b0, 16'hBBBB, 1'b0, 1'b0);
        chk("resync commit", 64'(bus0.count), 64'd1);
        pop();
        chk("resync frame", 64'(bus0.rd_data), 64'hBBBB_AAAA);
        clr();

        // Start-of-frame at channel 0 is an ordinary write.
        cyc(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0006, 1'b0, 1'b0);
        chk("sof ch0 no sync_err", 64'(bus0.sync_err), 64'd0);
        pop();
        chk("sof ch0 frame", 64'(bus0.rd_data), 64'h0006_0005);

        // Commit + pop while empty: no bypass.
        cyc(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0202, 1'b1, 1'b0);
        chk("empty c+p underflow", 64'(bus0.underflow), 64'd1);
        chk("empty c+p count", 64'(bus0.count), 64'd1);
        chk("empty c+p rd_valid", 64'(bus0.rd_valid), 64'd0);
        pop();
        chk("empty c+p frame", 64'(bus0.rd_data), 64'h0202_0101);
        clr();

        // Commit + pop mid-occupancy.
        for (int k = 0; k < 3; k++) write_frame(16'h3100 + 16'(k), 16'h3200 + 16'(k));
        cyc(1'b1, 1'b0, 16'h3103, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h3203, 1'b1, 1'b0);
        chk("mid c+p count", 64'(bus0.count), 64'd3);
        chk("mid c+p frame", 64'(bus0.rd_data), 64'h3200_3100);
        repeat (3) pop();

        // Commit + pop while full: no overflow.
        for (int k = 1; k <= 16; k++) write_frame(16'h4100 + 16'(k), 16'h4200 + 16'(k));
        cyc(1'b1, 1'b0, 16'h4111, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h4211, 1'b1, 1'b0);
        chk("full c+p no ovf0", 64'(bus0.overflow), 64'd0);
        chk("full c+p no ovf1", 64'(bus1.overflow), 64'd0);
        chk("full c+p count", 64'(bus0.count), 64'd16);
        chk("full c+p frame", 64'(bus0.rd_data), 64'h4201_4101);
        repeat (16) pop();

        // Asynchronous reset with 5 frames stored and a half-written frame.
        for (int k = 0; k < 5; k++) write_frame(16'h5100 + 16'(k), 16'h5200 + 16'(k));
        cyc(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0);
        chk("pre-reset count", 64'(bus0.count), 64'd5);
        chk("pre-reset sync_err", 64'(bus0.sync_err), 64'd1);
        #2 reset = 1'b1;
        #1 chk_reset_state("async");
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 16'h0A0A, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0B0B, 1'b0, 1'b0);
        chk("post-reset count", 64'(bus0.count), 64'd1);
        chk("post-reset sync_err", 64'(bus0.sync_err), 64'd0);
        pop();
        chk("post-reset frame", 64'(bus0.rd_data), 64'h0B0B_0A0A);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
